// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, waits for each digit's pattern to settle,
// and decodes it back into a per-digit hex register bank with valid/err/frame flags.
module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_seg,
  input  logic [DIGITS-1:0]     i_an,
  output logic [4*DIGITS-1:0]   o_hex,
  output logic [DIGITS-1:0]     o_valid,
  output logic                  o_upd,
  output logic [2:0]            o_upd_idx,
  output logic                  o_err,
  output logic                  o_frame
);

  localparam int CW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t            r_state;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic [CW-1:0]     r_cnt;
  logic [DIGITS-1:0] r_seen;

  logic              w_oneHot;
  logic              w_same;
  logic              w_commit;
  logic [2:0]        w_idx;
  logic [4:0]        w_dec;
  logic [DIGITS-1:0] w_seenNext;
  logic              w_allSeen;

  // Returns {legal, value}; unknown patterns come back with legal=0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: return 5'h10;
      7'b0110000: return 5'h11;
      7'b1101101: return 5'h12;
      7'b1111001: return 5'h13;
      7'b0110011: return 5'h14;
      7'b1011011: return 5'h15;
      7'b1011111: return 5'h16;
      7'b1110010: return 5'h17;
      7'b1111111: return 5'h18;
      7'b1111011: return 5'h19;
      7'b1110111: return 5'h1A;
      7'b0011111: return 5'h1B;
      7'b1001110: return 5'h1C;
      7'b0111101: return 5'h1D;
      7'b1001111: return 5'h1E;
      7'b1000111: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  // The incoming sample is compared against the previous one, so the edge that
  // registers the STABLE-th identical sample is also the commit edge.
  always_comb begin
    w_oneHot   = $onehot(i_an);
    w_same     = ({i_an, i_seg} == {r_an, r_seg});
    w_commit   = (r_state == TRACK) && w_oneHot && w_same && (r_cnt == CW'(STABLE - 1));
    w_dec      = decode(i_seg);
    w_seenNext = r_seen | i_an;
    w_allSeen  = &w_seenNext;
    w_idx      = 3'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_an[d]) w_idx = 3'(d);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_an      <= '0;
      r_seg     <= '0;
      r_cnt     <= '0;
      r_seen    <= '0;
      o_hex     <= '0;
      o_valid   <= '0;
      o_upd     <= 1'b0;
      o_upd_idx <= 3'd0;
      o_err     <= 1'b0;
      o_frame   <= 1'b0;
    end else begin
      r_an    <= i_an;
      r_seg   <= i_seg;
      o_upd   <= 1'b0;
      o_err   <= 1'b0;
      o_frame <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_oneHot) begin
            r_state <= TRACK;
            r_cnt   <= CW'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        TRACK: begin
          if (!w_oneHot) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!w_same) begin
            r_cnt   <= CW'(1);
          end else if (w_commit) begin
            r_state <= HOLD;
            r_cnt   <= CW'(STABLE);
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (!w_oneHot) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!w_same) begin
            r_state <= TRACK;
            r_cnt   <= CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase

      if (w_commit) begin
        o_upd     <= 1'b1;
        o_upd_idx <= w_idx;
        o_err     <= ~w_dec[4];
        o_frame   <= w_allSeen;
        r_seen    <= w_allSeen ? '0 : w_seenNext;
        for (int d = 0; d < DIGITS; d++) begin
          if (i_an[d]) begin
            o_valid[d] <= w_dec[4];
            if (w_dec[4]) o_hex[4*d +: 4] <= w_dec[3:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Drives digit patterns onto the scan bus and checks every commit against a
// queue of expected {index, value, err, frame} records.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  an  = '0;
  logic [15:0] hex;
  logic [3:0]  valid;
  logic        upd;
  logic [2:0]  updIdx;
  logic        err;
  logic        frame;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         cycles;
    bit         commit;
    logic [2:0] idx;
    logic [3:0] val;
    bit         err;
  } vec_t;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] val;
    bit         err;
    bit         frame;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [3:0] seenModel = '0;
  logic [6:0] enc[16];

  seg7_scan_decoder #(.DIGITS(4), .STABLE(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_seg(seg), .i_an(an),
    .o_hex(hex), .o_valid(valid), .o_upd(upd), .o_upd_idx(updIdx),
    .o_err(err), .o_frame(frame)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds one bus pattern for the given number of rising edges; an expected
  // commit is queued, with frame predicted from a local model of the seen mask.
  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int cycles,
                               input bit commit, input logic [2:0] idx, input logic [3:0] val,
                               input bit e);
    exp_t x;
    @(negedge clk);
    an  = a;
    seg = s;
    if (commit) begin
      x.idx     = idx;
      x.val     = val;
      x.err     = e;
      seenModel = seenModel | (4'b0001 << idx);
      x.frame   = &seenModel;
      if (x.frame) seenModel = '0;
      sb.push_back(x);
    end
    repeat (cycles - 1) @(negedge clk);
  endtask

  // Monitor: every upd pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (upd === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_upd", {29'd0, updIdx}, 32'hFFFF_FFFF);
      end else begin
        x = sb.pop_front();
        checkOutput("upd_idx", updIdx, x.idx);
        checkOutput("err", err, x.err);
        checkOutput("frame", frame, x.frame);
        checkOutput("hex_field", hex[4*x.idx +: 4], x.val);
        checkOutput("valid_bit", valid[x.idx], !x.err);
      end
    end else if (!rst && (err === 1'b1 || frame === 1'b1)) begin
      checkOutput("pulse_without_upd", {err, frame}, 2'b00);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    enc = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    vecs.push_back('{4'b0001, 7'b0110000, 13, 1'b1, 3'd0, 4'h1, 1'b0});
    vecs.push_back('{4'b0000, 7'b0000000,  2, 1'b0, 3'd0, 4'h0, 1'b0});
    vecs.push_back('{4'b0010, 7'b1101101,  2, 1'b0, 3'd0, 4'h0, 1'b0});
    vecs.push_back('{4'b0010, 7'b1111001,  3, 1'b1, 3'd1, 4'h3, 1'b0});
    vecs.push_back('{4'b0000, 7'b0000000,  1, 1'b0, 3'd0, 4'h0, 1'b0});
    vecs.push_back('{4'b0100, 7'b1001110,  3, 1'b1, 3'd2, 4'hC, 1'b0});
    vecs.push_back('{4'b0100, 7'b0000001,  3, 1'b1, 3'd2, 4'hC, 1'b1});
    vecs.push_back('{4'b0000, 7'b0000000,  1, 1'b0, 3'd0, 4'h0, 1'b0});
    vecs.push_back('{4'b0001, 7'b0110000,  4, 1'b1, 3'd0, 4'h1, 1'b0});
    vecs.push_back('{4'b0011, 7'b0110000,  1, 1'b0, 3'd0, 4'h0, 1'b0});
    vecs.push_back('{4'b0010, 7'b1101101,  4, 1'b1, 3'd1, 4'h2, 1'b0});
    vecs.push_back('{4'b0000, 7'b0000000,  1, 1'b0, 3'd0, 4'h0, 1'b0});
    vecs.push_back('{4'b0100, 7'b1111001,  4, 1'b1, 3'd2, 4'h3, 1'b0});
    vecs.push_back('{4'b0011, 7'b1111001,  2, 1'b0, 3'd0, 4'h0, 1'b0});
    vecs.push_back('{4'b1000, 7'b0110011,  4, 1'b1, 3'd3, 4'h4, 1'b0});

    // Reset held two edges while the bus toggles.
    @(negedge clk);
    rst = 1'b1; an = 4'b0001; seg = 7'b0110000;
    @(negedge clk);
    an = 4'b0010; seg = 7'b1101101;
    @(negedge clk);
    checkOutput("rst_hex", hex, 16'h0000);
    checkOutput("rst_valid", valid, 4'h0);
    checkOutput("rst_upd", upd, 1'b0);
    checkOutput("rst_idx", updIdx, 3'd0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_frame", frame, 1'b0);
    rst = 1'b0; an = 4'b0000; seg = 7'b0000000;
    seenModel = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].an, vecs[i].seg, vecs[i].cycles, vecs[i].commit,
                    vecs[i].idx, vecs[i].val, vecs[i].err);
    end
    @(negedge clk);
    checkOutput("scan_hex", hex, 16'h4321);
    checkOutput("scan_valid", valid, 4'hF);

    // Round-trip every code through the encoder table, one digit slot each.
    for (int c = 0; c < 16; c++) begin
      applyStimulus(4'b0001 << (c % 4), enc[c], 3, 1'b1, 3'(c % 4), 4'(c), 1'b0);
    end
    @(negedge clk);
    checkOutput("rt_hex", hex, 16'hFEDC);
    checkOutput("rt_valid", valid, 4'hF);

    // Reset on the edge where the count would reach STABLE must abort the commit.
    applyStimulus(4'b0001, enc[5], 2, 1'b0, 3'd0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; an = 4'b0000; seg = 7'b0000000;
    seenModel = '0;
    checkOutput("abort_hex", hex, 16'h0000);
    checkOutput("abort_valid", valid, 4'h0);
    repeat (5) @(negedge clk);
    checkOutput("abort_hex_after", hex, 16'h0000);
    checkOutput("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
